key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Debounces and conditions the raw, active-low KEY pushbuttons of the DE2i-150 board, one channel per key.
- For each key it produces a clean level, one-cycle press and release pulses, and a hold-to-repeat step pulse.
- It sits directly upstream of the board-level counters and the bound-flasher and edge logic, replacing raw KEY usage.

Parameters:
NUM_KEYS, 4, number of independent key channels
ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed
DEBOUNCE_CYC, 500000, cycles a new level must stay stable before it is accepted (10 ms at 50 MHz); must be >= 1
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = key_repeat fires only on press
REPEAT_DLY, 25000000, cycles of hold before the first auto-repeat (500 ms); must be >= 1
REPEAT_PER, 5000000, cycles between later auto-repeats (100 ms); must be >= 1
CNT_W, 25, counter width; must hold max(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER)

Ports:
clk  input  1  system clock (CLOCK_50)
rst  input  1  synchronous, active-high reset
key_in  input  NUM_KEYS  raw asynchronous key pins
key_level  output  NUM_KEYS  debounced state, 1 = pressed
key_press  output  NUM_KEYS  one-cycle pulse on accepted press
key_release  output  NUM_KEYS  one-cycle pulse on accepted release
key_repeat  output  NUM_KEYS  one-cycle step pulse: fires on press, then on each auto-repeat

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Channels are fully independent. Simultaneous events on different keys are handled in parallel with no priority.
- Synchronizer: a 2-FF chain per key. Its reset value is the released level (1 when ACTIVE_LOW=1). The normalized signal is pressed = sync2 XOR ACTIVE_LOW.
- Per-channel FSM, four states: RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. It uses a debounce counter dcnt and a repeat counter rcnt, each CNT_W bits.
  - RELEASED: if pressed, go to PRESS_CHK with dcnt=0.
  - PRESS_CHK: if not pressed, return to RELEASED with no output (bounce rejected). Else, if dcnt==DEBOUNCE_CYC-1, go to PRESSED: key_level<=1, key_press and key_repeat pulse, rcnt=0, repeat target=REPEAT_DLY. Otherwise dcnt++.
  - PRESSED: if not pressed, go to RELEASE_CHK with dcnt=0; key_level stays 1. Else, if REPEAT_EN, increment rcnt; when rcnt==target-1, pulse key_repeat, set rcnt=0 and target=REPEAT_PER.
  - RELEASE_CHK: if pressed, return to PRESSED; rcnt and target hold their values and resume counting (no new press pulse). Else, if dcnt==DEBOUNCE_CYC-1, go to RELEASED: key_level<=0, key_release pulse. Otherwise dcnt++.
- All outputs are registered. Each pulse is high for exactly one cycle.
- Latency: a clean edge held stable appears on the outputs DEBOUNCE_CYC+3 cycles after the first clk edge that samples the new level. This is 2 synchronizer cycles, 1 FSM entry cycle and DEBOUNCE_CYC check cycles.
- Any bounce inside a CHK state fully restarts qualification; dcnt never accumulates across bounces.
- Counters never wrap: dcnt is cleared on every CHK entry, and rcnt is cleared on every repeat pulse.
- Reset (any cycle, including mid-press):
  - next cycle: all outputs 0, FSM in RELEASED, counters 0, synchronizers at released level.
  - a key still held after rst deasserts is re-qualified and produces a fresh key_press DEBOUNCE_CYC+3 cycles later.
- rst has priority over every other event.

Decomposition:
- Shared package key_pkg holds:
  - the FSM state encodings (2-bit: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3);
  - the 50 MHz default timing constants.
- Sub-module key_debounce_ch implements one channel: synchronizer, FSM, counters and output registers.
- key_debounce instantiates NUM_KEYS copies of it in a generate loop.

Test Plan:
Bench parameters: NUM_KEYS=2, DEBOUNCE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3. Cycle 0 is the first clk edge that samples the new key_in value.
1. Hold key_in=2'b11 and pulse rst for 3 cycles -> all outputs 0 during reset and for 30 cycles after.
2. Set key_in[0]=0 at cycle 0 and hold -> key_press[0]=key_repeat[0]=1 in cycle 7 only, key_level[0]=1 from cycle 7, key_release[0] never pulses, key 1 outputs all 0.
3. Continue holding key 0 -> key_repeat[0] pulses in cycles 17, 20, 23, 26; key_press[0] does not pulse again. Repeat test 2 with REPEAT_EN=0 -> only the cycle-7 key_repeat.
4. Toggle key_in[0] every 2 cycles for 20 cycles, then hold it at 1 -> no pulses, key_level[0]=0 throughout.
5. Release from the PRESSED state with a 1-cycle re-press glitch 2 cycles into RELEASE_CHK -> key_level[0] stays 1, no key_press. key_release[0] pulses and key_level[0] drops together, 7 cycles after the first stable-released sample that follows the glitch.
6. Press both keys at cycle 0 -> key_press=2'b11 in cycle 7. Then assert rst for 1 cycle at cycle 12 -> outputs 0 in cycle 13. With both keys still held, key_press=2'b11 again 7 cycles after the first post-reset sampling edge.

Source files
------------

// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the KEY pushbutton debouncer.
//   - key_state_e : per-channel FSM state encoding (2 bits)
//   - DEF_*       : default timing constants for a 50 MHz clock
// -----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED    = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } key_state_e;

    // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYC = 32'd500000;
    localparam int unsigned DEF_REPEAT_DLY   = 32'd25000000;
    localparam int unsigned DEF_REPEAT_PER   = 32'd5000000;
    localparam int unsigned DEF_CNT_W        = 32'd25;

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One debounce channel: 2-FF synchronizer, 4-state qualification FSM,
// debounce/repeat counters and registered outputs.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   key_i      in   raw asynchronous key pin
//   level_o    out  debounced level, 1 = pressed
//   press_o    out  one-cycle pulse on accepted press
//   release_o  out  one-cycle pulse on accepted release
//   repeat_o   out  one-cycle pulse on press and on each auto-repeat
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter bit          REPEAT_EN    = 1'b1,
    parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    // Terminal counts are stored as "target - 1" so each compare is a plain equality
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DLY - 32'd1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PER - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             REL_LVL  = ACTIVE_LOW;

    logic             sync1_q, sync2_q;
    logic             pressed_s;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    // 1 while waiting for the first (long) repeat delay, 0 for the periodic ones
    logic             first_q, first_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;

    // Normalise polarity so that 1 always means "pressed"
    assign pressed_s = sync2_q ^ ACTIVE_LOW;

    // Next-state, counter and output decode for the qualification FSM
    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        rcnt_d    = rcnt_q;
        first_d   = first_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (pressed_s) begin
                    state_d = ST_PRESS_CHK;
                    dcnt_d  = CNT_ZERO;
                end else begin
                    state_d = ST_RELEASED;
                end
            end
            ST_PRESS_CHK: begin
                if (!pressed_s) begin
                    // bounce: drop back without any output
                    state_d = ST_RELEASED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d  = ST_PRESSED;
                    level_d  = 1'b1;
                    press_d  = 1'b1;
                    repeat_d = 1'b1;
                    rcnt_d   = CNT_ZERO;
                    first_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!pressed_s) begin
                    state_d = ST_RELEASE_CHK;
                    dcnt_d  = CNT_ZERO;
                end else if (REPEAT_EN) begin
                    if (rcnt_q == (first_q ? DLY_LAST : PER_LAST)) begin
                        repeat_d = 1'b1;
                        rcnt_d   = CNT_ZERO;
                        first_d  = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_ONE;
                    end
                end else begin
                    rcnt_d = rcnt_q;
                end
            end
            ST_RELEASE_CHK: begin
                if (pressed_s) begin
                    // glitch during release: resume repeat timing where it paused
                    state_d = ST_PRESSED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = ST_RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                level_d = 1'b0;
            end
        endcase
    end

    // Synchronizer, FSM state, counters and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= REL_LVL;
            sync2_q   <= REL_LVL;
            state_q   <= ST_RELEASED;
            dcnt_q    <= CNT_ZERO;
            rcnt_q    <= CNT_ZERO;
            first_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= key_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            rcnt_q    <= rcnt_d;
            first_q   <= first_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces NUM_KEYS raw pushbuttons; channels are fully independent.
// Ports:
//   clk          in   system clock (CLOCK_50)
//   rst          in   synchronous active-high reset
//   key_in       in   raw asynchronous key pins
//   key_level    out  debounced state, 1 = pressed
//   key_press    out  one-cycle pulse on accepted press
//   key_release  out  one-cycle pulse on accepted release
//   key_repeat   out  pulse on press, then on each auto-repeat
// -----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS     = 32'd4,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter bit          REPEAT_EN    = 1'b1,
    parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
    parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .ACTIVE_LOW  (ACTIVE_LOW),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .REPEAT_EN   (REPEAT_EN),
            .REPEAT_DLY  (REPEAT_DLY),
            .REPEAT_PER  (REPEAT_PER),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .key_i    (key_in[g]),
            .level_o  (key_level[g]),
            .press_o  (key_press[g]),
            .release_o(key_release[g]),
            .repeat_o (key_repeat[g])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (NUM_KEYS=2, DEBOUNCE_CYC=4, REPEAT_DLY=10,
// REPEAT_PER=3). Cycle n is the clock period that ends with edge n, where
// edge 0 is the first edge sampling a new key_in value; outputs for cycle n
// are therefore sampled 1 ns after edge n-1.
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] lvl, prs, rel, rpt;
    logic [1:0] lvl_nr, prs_nr, rel_nr, rpt_nr;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEYS(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .REPEAT_EN(1'b1),
        .REPEAT_DLY(10), .REPEAT_PER(3), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_level(lvl), .key_press(prs), .key_release(rel), .key_repeat(rpt)
    );

    key_debounce #(
        .NUM_KEYS(2), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYC(4), .REPEAT_EN(1'b0),
        .REPEAT_DLY(10), .REPEAT_PER(3), .CNT_W(8)
    ) dut_nr (
        .clk(clk), .rst(rst), .key_in(key_in),
        .key_level(lvl_nr), .key_press(prs_nr), .key_release(rel_nr), .key_repeat(rpt_nr)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        key_in = 2'b11;

        // Test 1: reset with keys released, then idle
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("t1_rst_outs", 8'({lvl, prs, rel, rpt}), 8'd0);
            check("t1_rst_outs_nr", 8'({lvl_nr, prs_nr, rel_nr, rpt_nr}), 8'd0);
        end
        rst = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            check("t1_idle_outs", 8'({lvl, prs, rel, rpt}), 8'd0);
            check("t1_idle_outs_nr", 8'({lvl_nr, prs_nr, rel_nr, rpt_nr}), 8'd0);
        end

        // Tests 2/3: press and hold key 0
        key_in = 2'b10;
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk); #1;
            check("t2_press0", 8'(prs[0]), 8'(n == 7));
            check("t2_level0", 8'(lvl[0]), 8'(n >= 7));
            check("t2_release0", 8'(rel[0]), 8'd0);
            check("t2_key1", 8'({lvl[1], prs[1], rel[1], rpt[1]}), 8'd0);
            check("t3_repeat0", 8'(rpt[0]),
                  8'((n == 7) || (n == 17) || (n == 20) || (n == 23) || (n == 26)));
            check("t3_norpt_repeat0", 8'(rpt_nr[0]), 8'(n == 7));
            check("t3_norpt_press0", 8'(prs_nr[0]), 8'(n == 7));
        end

        // Clean release of key 0
        key_in = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            check("rel_release0", 8'(rel[0]), 8'(n == 7));
            check("rel_level0", 8'(lvl[0]), 8'(n < 7));
            check("rel_press0", 8'(prs[0]), 8'd0);
            check("rel_norpt_release0", 8'(rel_nr[0]), 8'(n == 7));
        end

        // Test 4: bouncing key 0 (2 cycles low, 2 high) never qualifies
        for (int n = 0; n < 20; n++) begin
            key_in[0] = (((n / 2) % 2) == 0) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            check("t4_bounce_outs", 8'({lvl, prs, rel, rpt}), 8'd0);
        end
        key_in[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            check("t4_settle_outs", 8'({lvl, prs, rel, rpt}), 8'd0);
        end

        // Test 5: press, then release with a 1-cycle re-press glitch
        key_in[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            check("t5_pre_level0", 8'(lvl[0]), 8'(n >= 7));
        end
        for (int n = 0; n < 14; n++) begin
            key_in[0] = (n == 2) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            // stable release is first sampled at edge 3, so release lands in cycle 10
            check("t5_level0", 8'(lvl[0]), 8'((n + 1) < 10));
            check("t5_release0", 8'(rel[0]), 8'((n + 1) == 10));
            check("t5_press0", 8'(prs[0]), 8'd0);
        end

        // Test 6: press both keys, reset mid-press, re-qualification
        key_in = 2'b00;
        for (int n = 0; n < 22; n++) begin
            rst = (n == 12);
            @(posedge clk); #1;
            check("t6_press", 8'(prs), ((n + 1) == 7 || (n + 1) == 20) ? 8'd3 : 8'd0);
            check("t6_level",  8'(lvl),
                  (((n + 1) >= 7 && (n + 1) <= 12) || (n + 1) >= 20) ? 8'd3 : 8'd0);
            if ((n + 1) == 13) begin
                check("t6_rst_outs", 8'({lvl, prs, rel, rpt}), 8'd0);
            end
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
